// File: rtl/ra_stack_pkg.sv
// Shared types and constants for the return-address shadow stack.
package ra_stack_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  localparam int OVF_DROP = 0;
  localparam int OVF_WRAP = 1;

endpackage

// File: rtl/ra_stack_regs.sv
// Flop array holding the return addresses: one write port, one combinational read port.
module ra_stack_regs
  import ra_stack_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_r [DEPTH];

  // Storage update: reset wipes every entry, otherwise a single write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ra_shadow_stack.sv
// Return-address shadow stack: checks each return target against the recorded call site.
module ra_shadow_stack
  import ra_stack_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 16,
  parameter  int OVF_MODE = 0,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            ena,
  input  logic            hold,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  input  logic [XLEN-1:0] pop_target,
  input  logic            clr_err,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_mismatch,
  output logic            overflow,
  output logic            underflow,
  output logic            trap_req
);

  state_t          state_r;
  logic [AW-1:0]   sp_r;
  logic [CW-1:0]   count_r;
  logic            mismatch_r;
  logic            overflow_r;
  logic            underflow_r;
  logic            trap_r;

  logic            eff_s;
  logic            full_s;
  logic            empty_s;
  logic            differ_s;
  logic            we_s;
  logic [AW-1:0]   waddr_s;
  logic [AW-1:0]   raddr_s;
  logic [XLEN-1:0] rdata_s;
  logic [XLEN-1:0] top_s;

  ra_stack_regs #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_regs (
    .clk   (clk),
    .rst   (Rst),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (push_data),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Operation qualification, top-of-stack view and array write port steering
  always_comb begin
    eff_s    = (state_r == RUN) && ena && !hold && !clr_err;
    full_s   = (count_r == CW'(DEPTH));
    empty_s  = (count_r == {CW{1'b0}});
    raddr_s  = sp_r - AW'(1);
    if (empty_s) begin
      top_s = {XLEN{1'b0}};
    end else begin
      top_s = rdata_s;
    end
    differ_s = (top_s != pop_target);
    we_s     = 1'b0;
    waddr_s  = sp_r;
    if (eff_s && push) begin
      if (pop && !empty_s) begin
        // Call and return in one cycle replace the top entry in place
        we_s    = 1'b1;
        waddr_s = raddr_s;
      end else if (!full_s || (OVF_MODE == OVF_WRAP)) begin
        we_s = 1'b1;
      end else begin
        we_s = 1'b0;
      end
    end else begin
      we_s = 1'b0;
    end
  end

  // Pointer, count, FSM, sticky flags and the trap pulse
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r     <= RUN;
      sp_r        <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      mismatch_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      trap_r      <= 1'b0;
    end else begin
      trap_r <= 1'b0;
      if (clr_err) begin
        state_r     <= RUN;
        mismatch_r  <= 1'b0;
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end else if (eff_s) begin
        case ({push, pop})
          2'b10: begin
            if (!full_s) begin
              sp_r    <= sp_r + AW'(1);
              count_r <= count_r + CW'(1);
            end else begin
              overflow_r <= 1'b1;
              if (OVF_MODE == OVF_WRAP) begin
                sp_r <= sp_r + AW'(1);
              end
            end
          end
          2'b01: begin
            if (!empty_s) begin
              sp_r    <= sp_r - AW'(1);
              count_r <= count_r - CW'(1);
              if (differ_s) begin
                mismatch_r <= 1'b1;
                trap_r     <= 1'b1;
                state_r    <= FAULT;
              end
            end else begin
              underflow_r <= 1'b1;
            end
          end
          2'b11: begin
            if (!empty_s) begin
              if (differ_s) begin
                mismatch_r <= 1'b1;
                trap_r     <= 1'b1;
                state_r    <= FAULT;
              end
            end else begin
              sp_r        <= sp_r + AW'(1);
              count_r     <= count_r + CW'(1);
              underflow_r <= 1'b1;
            end
          end
          default: begin
            sp_r <= sp_r;
          end
        endcase
      end
    end
  end

  assign top            = top_s;
  assign count          = count_r;
  assign stack_full     = full_s;
  assign stack_empty    = empty_s;
  assign stack_mismatch = mismatch_r;
  assign overflow       = overflow_r;
  assign underflow      = underflow_r;
  assign trap_req       = trap_r;

endmodule

// File: tb/tb_ra_shadow_stack.sv
// Scenario bench for ra_shadow_stack: a drop-policy and a wrap-policy instance share stimulus.
module tb_ra_shadow_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        hold;
  logic        push;
  logic        pop;
  logic [31:0] push_data;
  logic [31:0] pop_target;
  logic        clr_err;

  logic [31:0] a_top,  b_top;
  logic [2:0]  a_count, b_count;
  logic        a_full, a_empty, a_mis, a_ovf, a_unf, a_trap;
  logic        b_full, b_empty, b_mis, b_ovf, b_unf, b_trap;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  ra_shadow_stack #(.XLEN(32), .DEPTH(4), .OVF_MODE(0)) u_drop (
    .clk(clk), .Rst(rst), .ena(ena), .hold(hold), .push(push), .pop(pop),
    .push_data(push_data), .pop_target(pop_target), .clr_err(clr_err),
    .top(a_top), .count(a_count), .stack_full(a_full), .stack_empty(a_empty),
    .stack_mismatch(a_mis), .overflow(a_ovf), .underflow(a_unf), .trap_req(a_trap)
  );

  ra_shadow_stack #(.XLEN(32), .DEPTH(4), .OVF_MODE(1)) u_wrap (
    .clk(clk), .Rst(rst), .ena(ena), .hold(hold), .push(push), .pop(pop),
    .push_data(push_data), .pop_target(pop_target), .clr_err(clr_err),
    .top(b_top), .count(b_count), .stack_full(b_full), .stack_empty(b_empty),
    .stack_mismatch(b_mis), .overflow(b_ovf), .underflow(b_unf), .trap_req(b_trap)
  );

  task automatic op(input logic p, input logic q, input logic [31:0] pd, input logic [31:0] pt);
    push = p; pop = q; push_data = pd; pop_target = pt;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    push = 1'b1; push_data = 32'hDEAD;
    do_reset();
    push = 1'b0;
    n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: actual %0d required 0", a_count); end
    n_checks++; if (a_top !== 32'h0) begin n_fail++; $display("FAIL reset_top: actual %0h required 0", a_top); end
    n_checks++; if ({a_empty, a_full} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full: actual %b required 10", {a_empty, a_full}); end
    n_checks++; if ({a_mis, a_ovf, a_unf, a_trap} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: actual %b required 0000", {a_mis, a_ovf, a_unf, a_trap}); end
  endtask

  task automatic test_matched();
    do_reset();
    op(1'b1, 1'b0, 32'h100, 32'h0); exp_q.push_back(32'h100);
    op(1'b1, 1'b0, 32'h200, 32'h0); exp_q.push_back(32'h200);
    n_checks++; if (a_count !== 3'd2) begin n_fail++; $display("FAIL matched_count2: actual %0d required 2", a_count); end
    for (int i = 1; i >= 0; i--) begin
      exp_v = exp_q.pop_back();
      n_checks++; if (a_top !== exp_v) begin n_fail++; $display("FAIL matched_top: actual %0h required %0h", a_top, exp_v); end
      op(1'b0, 1'b1, 32'h0, exp_v);
      n_checks++; if (a_count !== 3'(i)) begin n_fail++; $display("FAIL matched_count: actual %0d required %0d", a_count, i); end
    end
    n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL matched_empty: actual %b required 1", a_empty); end
    n_checks++; if ({a_mis, a_ovf, a_unf, a_trap} !== 4'b0000) begin n_fail++; $display("FAIL matched_flags: actual %b required 0000", {a_mis, a_ovf, a_unf, a_trap}); end
  endtask

  task automatic test_mismatch();
    do_reset();
    op(1'b1, 1'b0, 32'h300, 32'h0);
    n_checks++; if (a_trap !== 1'b0) begin n_fail++; $display("FAIL mis_trap_early: actual %b required 0", a_trap); end
    op(1'b0, 1'b1, 32'h0, 32'h304);
    n_checks++; if ({a_mis, a_trap} !== 2'b11) begin n_fail++; $display("FAIL mis_flag_trap: actual %b required 11", {a_mis, a_trap}); end
    n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL mis_count: actual %0d required 0", a_count); end
    op(1'b1, 1'b0, 32'h400, 32'h0);
    n_checks++; if (a_trap !== 1'b0) begin n_fail++; $display("FAIL mis_trap_pulse: actual %b required 0", a_trap); end
    n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL mis_fault_push: actual %0d required 0", a_count); end
    n_checks++; if (a_mis !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: actual %b required 1", a_mis); end
    clr_err = 1'b1;
    op(1'b1, 1'b0, 32'h500, 32'h0);
    clr_err = 1'b0;
    n_checks++; if ({a_mis, a_count} !== 4'b0000) begin n_fail++; $display("FAIL mis_clr_priority: actual %b required 0000", {a_mis, a_count}); end
    op(1'b1, 1'b0, 32'h600, 32'h0);
    n_checks++; if (a_top !== 32'h600 || a_count !== 3'd1) begin n_fail++; $display("FAIL mis_run_again: actual %0h/%0d required 600/1", a_top, a_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      op(1'b1, 1'b0, 32'(v), 32'h0);
      exp_q.push_back(32'(v));
      if (exp_q.size() > 4) void'(exp_q.pop_front());
    end
    n_checks++; if ({a_count, a_top} !== {3'd4, 32'd4}) begin n_fail++; $display("FAIL ovf_drop: actual %0d/%0h required 4/4", a_count, a_top); end
    n_checks++; if ({a_ovf, a_full} !== 2'b11) begin n_fail++; $display("FAIL ovf_drop_flag: actual %b required 11", {a_ovf, a_full}); end
    n_checks++; if ({b_count, b_top, b_ovf} !== {3'd4, 32'd5, 1'b1}) begin n_fail++; $display("FAIL ovf_wrap: actual %0d/%0h/%b required 4/5/1", b_count, b_top, b_ovf); end
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_back();
      n_checks++; if (b_top !== exp_v) begin n_fail++; $display("FAIL wrap_pop_top: actual %0h required %0h", b_top, exp_v); end
      op(1'b0, 1'b1, 32'h0, exp_v);
    end
    n_checks++; if ({b_mis, b_count, b_empty} !== 5'b00001) begin n_fail++; $display("FAIL wrap_drained: actual %b required 00001", {b_mis, b_count, b_empty}); end
  endtask

  task automatic test_underflow();
    do_reset();
    op(1'b0, 1'b1, 32'h0, 32'h44);
    n_checks++; if ({a_unf, a_trap, a_mis, a_count} !== 6'b100000) begin n_fail++; $display("FAIL unf_pop: actual %b required 100000", {a_unf, a_trap, a_mis, a_count}); end
    op(1'b1, 1'b0, 32'hAA, 32'h0);
    op(1'b0, 1'b1, 32'h0, 32'hAA);
    n_checks++; if ({a_mis, a_count} !== 4'b0000) begin n_fail++; $display("FAIL unf_sp_kept: actual %b required 0000", {a_mis, a_count}); end
    do_reset();
    op(1'b1, 1'b1, 32'hBB, 32'h0);
    n_checks++; if ({a_unf, a_count, a_top} !== {1'b1, 3'd1, 32'hBB}) begin n_fail++; $display("FAIL unf_pushpop: actual %b/%0d/%0h required 1/1/bb", a_unf, a_count, a_top); end
  endtask

  task automatic test_simul_hold();
    do_reset();
    op(1'b1, 1'b0, 32'h10, 32'h0);
    op(1'b1, 1'b1, 32'h20, 32'h10);
    n_checks++; if ({a_top, a_count, a_mis} !== {32'h20, 3'd1, 1'b0}) begin n_fail++; $display("FAIL simul: actual %0h/%0d/%b required 20/1/0", a_top, a_count, a_mis); end
    hold = 1'b1;
    op(1'b1, 1'b1, 32'h30, 32'h20);
    op(1'b1, 1'b0, 32'h40, 32'h0);
    hold = 1'b0;
    n_checks++; if ({a_top, a_count, a_mis, a_unf} !== {32'h20, 3'd1, 2'b00}) begin n_fail++; $display("FAIL hold: actual %0h/%0d required 20/1", a_top, a_count); end
    ena = 1'b0;
    op(1'b0, 1'b1, 32'h0, 32'h99);
    ena = 1'b1;
    n_checks++; if ({a_top, a_count, a_mis} !== {32'h20, 3'd1, 1'b0}) begin n_fail++; $display("FAIL ena_off: actual %0h/%0d required 20/1", a_top, a_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int v = 0; v < 3; v++) op(1'b1, 1'b0, 32'h70 + 32'(v), 32'h0);
    push = 1'b1; push_data = 32'h77;
    do_reset();
    push = 1'b0;
    n_checks++; if ({a_count, a_top, a_empty, a_full} !== {3'd0, 32'h0, 2'b10}) begin n_fail++; $display("FAIL rstmid_state: actual %0d/%0h/%b required 0/0/10", a_count, a_top, {a_empty, a_full}); end
    n_checks++; if ({a_mis, a_ovf, a_unf, a_trap} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags: actual %b required 0000", {a_mis, a_ovf, a_unf, a_trap}); end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; hold = 1'b0; push = 1'b0; pop = 1'b0;
    push_data = 32'h0; pop_target = 32'h0; clr_err = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_matched();
    test_mismatch();
    test_overflow();
    test_underflow();
    test_simul_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ra_shadow_stack.md
RA_SHADOW_STACK -- requirements
Module: ra_shadow_stack

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there SHALL be no other clock or reset.
REQ-002 Parameter XLEN, 32, width of a stored return address.
REQ-003 Parameter DEPTH, 16, number of entries; legal values are powers of two, 2 or more.
REQ-004 Parameter OVF_MODE, 0, overflow policy: 0 drops the push and flags it; 1 overwrites the oldest entry (circular).
REQ-005 Derived constant CW = clog2(DEPTH+1), width of count.
REQ-006 clk  in  1  system clock; all state updates on its rising edge.
REQ-007 Rst  in  1  synchronous active-high reset.
REQ-008 ena  in  1  stack enable; when 0, push and pop are ignored.
REQ-009 hold  in  1  pipeline stall (mem_hold or dbg); when 1, push and pop are ignored.
REQ-010 push  in  1  call seen (jal/jalr with rd != 0).
REQ-011 pop  in  1  return seen (jalr with rd == 0).
REQ-012 push_data  in  XLEN  return address to store (caller PC + 4).
REQ-013 pop_target  in  XLEN  actual jump target, compared against the top of stack.
REQ-014 clr_err  in  1  clears the sticky flags and leaves FAULT.
REQ-015 top  out  XLEN  current top entry; 0 when empty.
REQ-016 count  out  CW  number of valid entries.
REQ-017 stack_full, stack_empty  out  1 each  count == DEPTH and count == 0 respectively.
REQ-018 stack_mismatch, overflow, underflow  out  1 each  sticky error flags.
REQ-019 trap_req  out  1  one-cycle pulse requesting a core trap.

Function
REQ-020 Storage SHALL be a DEPTH x XLEN flop array with a pointer sp (log2 DEPTH bits) that wraps modulo DEPTH; top SHALL read the entry at sp-1 combinationally.
REQ-021 The FSM SHALL have two states, RUN and FAULT; push and pop take effect only in RUN, with ena=1 and hold=0 (this is an "effective" operation).
REQ-022 Push only, not full: write push_data at sp, then sp+1 and count+1.
REQ-023 Push only, full, OVF_MODE=0: the array, sp and count are unchanged and overflow is set.
REQ-024 Push only, full, OVF_MODE=1: write at sp, then sp+1 (wrapping), count stays DEPTH, and overflow is set.
REQ-025 Pop only, not empty: sp-1 and count-1; if top != pop_target, set stack_mismatch, raise trap_req on the next cycle, and enter FAULT.
REQ-026 Pop only, empty: no pointer change and no comparison; underflow is set; no trap.
REQ-027 Push and pop together, not empty: compare pop_target with top as in REQ-025; top is overwritten with push_data; sp and count are unchanged.
REQ-028 Push and pop together, empty: treated as a push only, and underflow is set.
REQ-029 All flags and count SHALL change one cycle after the effective operation.
REQ-030 trap_req SHALL be high for exactly one cycle per mismatch.
REQ-031 In FAULT, all push and pop operations are ignored; the array and flags hold.
REQ-032 clr_err=1 in any state SHALL clear stack_mismatch, overflow and underflow and move the FSM to RUN; contents and count are kept.
REQ-033 If clr_err and an effective op arrive in the same cycle, clr_err takes priority and the op is discarded.
REQ-034 Comparison SHALL use the full XLEN bits; there is no arithmetic beyond pointer and count increment/decrement.

Reset
REQ-035 Rst SHALL override every other input, including in the middle of an operation.
REQ-036 Reset values: sp=0, count=0, stack_empty=1, stack_full=0, top=0, all error flags=0, trap_req=0, FSM=RUN.
REQ-037 Reset SHALL clear all array entries to 0.

Structure
REQ-038 Package ra_stack_pkg SHALL hold the FSM state enum (RUN, FAULT) and the OVF_MODE constants (OVF_DROP=0, OVF_WRAP=1).
REQ-039 The flop array with its write port SHALL be one sub-module, ra_stack_regs; pointer, count, FSM and flags stay in ra_shadow_stack.

Verification
REQ-040 Matched returns: push 0x100, push 0x200, then pop with 0x200 and pop with 0x100 -> top reads 0x200 then 0x100; count 2,1,0; stack_empty=1 at the end; no flags set.
REQ-041 Mismatch: push 0x300, then pop with 0x304 -> stack_mismatch=1, a single trap_req pulse one cycle later, FSM=FAULT; a following push 0x400 is ignored (count stays 0); clr_err returns the FSM to RUN.
REQ-042 Overflow, OVF_MODE=0, DEPTH=4: push 1 to 5 -> count=4, top=4, overflow=1; OVF_MODE=1 with the same pushes -> count=4, top=5, and four pops return 5,4,3,2 with no mismatch.
REQ-043 Underflow: pop on an empty stack -> underflow=1, count=0, trap_req=0, sp unchanged.
REQ-044 Simultaneous ops and stall: with stack {0x10}, push 0x20 and pop 0x10 together -> top=0x20, count=1, no mismatch; the same op with hold=1 -> no change at all.
REQ-045 Reset mid-stream: after 3 pushes, assert Rst together with push -> all reset values of REQ-036, count=0.
